crossing_sync_bank: RTL and testbench
=====================================

Name: crossing_sync_bank

Overview:
- Multi-channel input-capture register bank. Successor to the single enabled capture register: adds NCH independent channels, a DEPTH-stage synchroniser chain per channel, a stability filter and a one-cycle change pulse.
- Sits between raw GPIO pins / foreign-domain signals and the GPIOCP command logic. Delivers filtered, stable samples and per-channel edge events.

Parameters:
- WIDTH, 1: bits per channel.
- NCH, 4: number of channels.
- DEPTH, 2: synchroniser stages per channel; legal range >= 2.
- INIT, all zeros: WIDTH-bit reset value, applied to every channel.
- FILT, 0: extra consecutive enabled cycles the synchronised value must hold before it is committed; 0 means no filtering.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  NCH  per-channel sample enable; bit c gates channel c.
- D_IN  in  NCH*WIDTH  raw inputs; channel c occupies bits [c*WIDTH +: WIDTH].
- Q_OUT  out  NCH*WIDTH  committed, filtered values; same packing as D_IN.
- CHG  out  NCH  registered one-cycle pulse when channel c commits a new value.
- STABLE  out  NCH  combinational; 1 when channel c's synchroniser tail equals its Q_OUT.

Behaviour:
- Reset (RST=1 at an edge) has priority over EN. It applies to every stage s[0..DEPTH-1], the last-tail register L, Q_OUT, the counter and CHG:
  - s[0..DEPTH-1], L and Q_OUT load INIT.
  - Counter loads 0; CHG loads 0.
  - After reset: STABLE = all ones.
- Per channel c, at an edge with RST=0 and EN[c]=1. T, L, Q and cnt below are pre-edge values:
  - Shift: s[0] <= D_IN slice; s[k] <= s[k-1]. Tail T = s[DEPTH-1].
  - L <= T.
  - Counter next value: cnt_n = (T != L) ? 0 : min(cnt+1, FILT).
  - cnt <= cnt_n.
  - Commit when T != Q and cnt_n >= FILT. On commit: Q_OUT <= T, CHG <= 1, cnt <= 0.
  - Otherwise: CHG <= 0, Q_OUT holds.
  - If T == Q: cnt <= 0 and no commit.
- At an edge with RST=0 and EN[c]=0: all channel c state holds, and CHG[c] <= 0.
  - Disabled cycles do not count toward the filter and do not break a run; they only stretch latency.
- Counter width: max(1, clog2(FILT+1)). Saturates at FILT, never wraps.
- Latency with EN held high: D_IN changes before edge t.
  - T shows the new value after edge t+DEPTH-1.
  - Q_OUT updates at edge t+DEPTH+FILT.
  - CHG is high for exactly the cycle after that edge.
- Glitch rejection: a new value that persists for fewer than FILT+1 consecutive enabled tail samples is never committed.
  - If the tail returns to Q, the counter clears.
  - If the tail moves to a third value (WIDTH>1), the run restarts at 0.
- Back-to-back commits: possible on consecutive enabled edges only when FILT=0.
- Channels are fully independent. Simultaneous commits on several channels assert several CHG bits in the same cycle.
- Reset mid-operation: any in-progress run is discarded, and no CHG is generated during or after reset.
- No combinational path from D_IN to any output. STABLE depends only on registers.

Test Plan:
- Reset: WIDTH=4, INIT=0x3, RST high 2 cycles, then low with D_IN=0x3 -> Q_OUT every channel 0x3, CHG=0, STABLE all 1, no CHG ever fires.
- Basic latency: DEPTH=2, FILT=0, EN=all 1, ch0 D_IN 0->1 before edge 10 -> Q_OUT[ch0]=1 after edge 12, CHG[0]=1 only in cycle after edge 12, STABLE[0]=0 between edges 11 and 12.
- Filter, FILT=3, DEPTH=2:
  - ch1 1-cycle and 3-cycle pulses to 1 -> Q_OUT[ch1] stays 0, CHG[1] never 1.
  - ch1 6-cycle pulse from edge 20 -> Q_OUT[ch1]=1 at edge 25, CHG[1] pulse once.
  - Return to 0 commits again 5 edges after the input falls.
- Enable gating: FILT=0, ch2 0->1 at edge 30, EN[2] low for edges 31-33 -> commit delayed to edge 35, all ch2 state frozen while disabled, CHG[2] low while disabled.
- Multi-channel, WIDTH=4: ch2 -> 0x5 and ch3 -> 0xA in the same cycle, ch3 glitching 0xA->0xB mid-run with FILT=2 -> ch2 commits on schedule; ch3 restarts its count and commits 0xB only after 3 stable tail samples; CHG bits independent.
- Reset mid-run: FILT=3, assert RST one edge before a commit is due -> Q_OUT=INIT, cnt=0, no CHG; after release, input still changed -> full DEPTH+FILT latency re-applies.

Source files
------------

// File: rtl/crossing_sync_bank.sv
// rtl/crossing_sync_bank.sv - multi-channel input synchroniser bank with stability filter,
// committed sample register and one-cycle change pulse per channel.
module crossing_sync_bank #(
   parameter int               WIDTH = 1,
   parameter int               NCH   = 4,
   parameter int               DEPTH = 2,
   parameter logic [WIDTH-1:0] INIT  = '0,
   parameter int               FILT  = 0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NCH-1:0]       EN,
   input  logic [NCH*WIDTH-1:0] D_IN,
   output logic [NCH*WIDTH-1:0] Q_OUT,
   output logic [NCH-1:0]       CHG,
   output logic [NCH-1:0]       STABLE
);

   localparam int CW = (FILT < 1) ? 1 : $clog2(FILT + 1);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [WIDTH-1:0] sync [DEPTH];
      logic [WIDTH-1:0] tail;
      logic [WIDTH-1:0] last;
      logic [WIDTH-1:0] q_r;
      logic [CW-1:0]    cnt;
      logic [CW-1:0]    cnt_n;
      logic             chg_r;
      logic             commit;

      assign tail = sync[DEPTH-1];

      // A change of tail value restarts the run; otherwise count up and saturate at FILT.
      always_comb begin
         cnt_n = '0;
         if (tail == last) begin
            cnt_n = (int'(cnt) < FILT) ? cnt + CW'(1) : CW'(FILT);
         end
      end

      assign commit = (tail != q_r) && (int'(cnt_n) >= FILT);

      always_ff @(posedge CLK) begin
         if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
               sync[k] <= INIT;
            end
            last  <= INIT;
            q_r   <= INIT;
            cnt   <= '0;
            chg_r <= 1'b0;
         end else if (EN[c]) begin
            sync[0] <= D_IN[c*WIDTH +: WIDTH];
            for (int k = 1; k < DEPTH; k++) begin
               sync[k] <= sync[k-1];
            end
            last <= tail;
            if (commit) begin
               q_r   <= tail;
               chg_r <= 1'b1;
               cnt   <= '0;
            end else begin
               chg_r <= 1'b0;
               cnt   <= (tail == q_r) ? '0 : cnt_n;
            end
         end else begin
            // Disabled: state frozen so the filter run only stretches, but the pulse still ends.
            chg_r <= 1'b0;
         end
      end

      assign Q_OUT[c*WIDTH +: WIDTH] = q_r;
      assign CHG[c]                  = chg_r;
      assign STABLE[c]               = (tail == q_r);
   end

endmodule

// File: tb/tb_crossing_sync_bank.sv
// tb/tb_crossing_sync_bank.sv - self-checking bench for crossing_sync_bank.
module tb_crossing_sync_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_on   = 1'b0;

   logic        rst_a, rst_b, rst_c;
   logic [3:0]  en_a, en_b, en_c;
   logic [3:0]  d_a, d_b, q_a, q_b;
   logic [3:0]  chg_a, chg_b, chg_c, stb_a, stb_b, stb_c;
   logic [15:0] d_c, q_c;

   crossing_sync_bank #(.WIDTH(1), .NCH(4), .DEPTH(2), .INIT(1'b0), .FILT(0)) u_a (
      .CLK(clk), .RST(rst_a), .EN(en_a), .D_IN(d_a), .Q_OUT(q_a), .CHG(chg_a), .STABLE(stb_a));
   crossing_sync_bank #(.WIDTH(1), .NCH(4), .DEPTH(2), .INIT(1'b0), .FILT(3)) u_b (
      .CLK(clk), .RST(rst_b), .EN(en_b), .D_IN(d_b), .Q_OUT(q_b), .CHG(chg_b), .STABLE(stb_b));
   crossing_sync_bank #(.WIDTH(4), .NCH(4), .DEPTH(3), .INIT(4'h3), .FILT(2)) u_c (
      .CLK(clk), .RST(rst_c), .EN(en_c), .D_IN(d_c), .Q_OUT(q_c), .CHG(chg_c), .STABLE(stb_c));

   typedef struct {
      logic       rst;
      logic [3:0] en;
      logic [3:0] d;
      logic [3:0] q;
      logic [3:0] chg;
      logic [3:0] stb;
   } vec_t;
   vec_t vecs[$];

   typedef struct {
      int         inst;
      int         ch;
      int         due;
      logic [3:0] val;
   } exp_t;
   exp_t sb[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, cyc);
   endtask

   task automatic add_vec(input logic rst, input logic [3:0] en, input logic [3:0] d,
                          input logic [3:0] q, input logic [3:0] chg, input logic [3:0] stb);
      vec_t v;
      v.rst = rst; v.en = en; v.d = d; v.q = q; v.chg = chg; v.stb = stb;
      vecs.push_back(v);
   endtask

   task automatic expect_commit(input int inst, input int ch, input int due, input logic [3:0] val);
      exp_t e;
      e.inst = inst; e.ch = ch; e.due = due; e.val = val;
      sb.push_back(e);
   endtask

   // Every CHG pulse must match a queued commit (edge, channel, value); a due entry without a pulse is missing.
   task automatic monitor(input int inst, input logic [3:0] chg, input logic [15:0] q, input int w);
      for (int c = 0; c < 4; c++) begin
         int         idx;
         logic [3:0] got;
         idx = -1;
         for (int i = 0; i < sb.size(); i++)
            if (sb[i].inst == inst && sb[i].ch == c && sb[i].due == cyc) idx = i;
         got = (w == 4) ? q[c*4 +: 4] : {3'b000, q[c]};
         if (chg[c] === 1'b1) begin
            n_checks++;
            if (idx < 0) begin
               $display("FAIL chg_inst%0d_ch%0d: got pulse expected none at edge %0d", inst, c, cyc);
            end else begin
               if (got === sb[idx].val) n_pass++;
               else $display("FAIL commit_inst%0d_ch%0d: got %h expected %h at edge %0d",
                             inst, c, got, sb[idx].val, cyc);
               sb.delete(idx);
            end
         end else if (idx >= 0) begin
            n_checks++;
            $display("FAIL commit_inst%0d_ch%0d: got no pulse expected %h at edge %0d",
                     inst, c, sb[idx].val, cyc);
            sb.delete(idx);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         monitor(1, chg_b, 16'(q_b), 1);
         monitor(2, chg_c, q_c, 4);
      end
   end

   initial begin
      int n;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      en_a = 4'h0; en_b = 4'hF; en_c = 4'hF;
      d_a = 4'h0; d_b = 4'h0; d_c = 16'h3333;
      steps(2);
      chk("c_rst_q", q_c, 16'h3333);
      chk("c_rst_chg", 16'(chg_c), 16'h0);
      chk("c_rst_stb", 16'(stb_c), 16'hF);
      rst_b = 1'b0; rst_c = 1'b0;
      mon_on = 1'b1;

      //      rst   en       d        q        chg      stb
      add_vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
      add_vec(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b1110);
      add_vec(1'b0, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0011, 4'b0001, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b1101);
      add_vec(1'b0, 4'b1111, 4'b0001, 4'b0011, 4'b0010, 4'b1101);
      add_vec(1'b0, 4'b1111, 4'b0001, 4'b0001, 4'b0010, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0101, 4'b0001, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1011, 4'b0101, 4'b0001, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1011, 4'b0101, 4'b0001, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1011, 4'b0101, 4'b0001, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0101, 4'b0001, 4'b0000, 4'b1011);
      add_vec(1'b0, 4'b1111, 4'b0101, 4'b0101, 4'b0100, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0101, 4'b0101, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b1101, 4'b0101, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b1101, 4'b0101, 4'b0000, 4'b0111);
      add_vec(1'b0, 4'b1111, 4'b1101, 4'b1101, 4'b1000, 4'b1111);
      add_vec(1'b0, 4'b0111, 4'b1101, 4'b1101, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0010, 4'b1101, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0010, 4'b1101, 4'b0000, 4'b0000);
      add_vec(1'b0, 4'b1111, 4'b0010, 4'b0010, 4'b1111, 4'b1111);
      add_vec(1'b0, 4'b1111, 4'b0010, 4'b0010, 4'b0000, 4'b1111);
      add_vec(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
      add_vec(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111);

      foreach (vecs[i]) begin
         rst_a = vecs[i].rst; en_a = vecs[i].en; d_a = vecs[i].d;
         step();
         chk($sformatf("a_q[%0d]", i), 16'(q_a), 16'(vecs[i].q));
         chk($sformatf("a_chg[%0d]", i), 16'(chg_a), 16'(vecs[i].chg));
         chk($sformatf("a_stb[%0d]", i), 16'(stb_a), 16'(vecs[i].stb));
      end
      chk("c_idle_q", q_c, 16'h3333);
      chk("c_idle_stb", 16'(stb_c), 16'hF);

      // FILT=3: pulses of 1 and 3 enabled samples never commit.
      d_b = 4'b0010; step(); d_b = 4'b0000; steps(6);
      d_b = 4'b0010; steps(3); d_b = 4'b0000; steps(6);
      chk("b_glitch_q", 16'(q_b), 16'h0);

      // 6-cycle pulse commits 5 edges after it starts, and again 5 edges after it falls.
      expect_commit(1, 1, cyc + 6, 4'h1);
      d_b = 4'b0010; steps(6);
      expect_commit(1, 1, cyc + 6, 4'h0);
      d_b = 4'b0000; steps(8);

      // Two disabled edges mid-run stretch the commit by two edges.
      expect_commit(1, 0, cyc + 8, 4'h1);
      d_b = 4'b0001; steps(3);
      en_b = 4'b1110; steps(2);
      chk("b_stb_frozen", 16'(stb_b), 16'hE);
      en_b = 4'hF; steps(6);
      chk("b_stretch_q", 16'(q_b), 16'h1);

      // Reset one edge before ch2 is due: run discarded, full latency after release.
      d_b = 4'b0101; steps(4);
      rst_b = 1'b1; step();
      chk("b_midrst_q", 16'(q_b), 16'h0);
      chk("b_midrst_chg", 16'(chg_b), 16'h0);
      chk("b_midrst_stb", 16'(stb_b), 16'hF);
      rst_b = 1'b0;
      expect_commit(1, 0, cyc + 6, 4'h1);
      expect_commit(1, 2, cyc + 6, 4'h1);
      steps(8);
      chk("b_final_q", 16'(q_b), 16'h5);

      // WIDTH=4, DEPTH=3, FILT=2: ch2 on schedule, ch3 glitch A->B restarts its run.
      n = cyc;
      expect_commit(2, 2, n + 6, 4'h5);
      expect_commit(2, 3, n + 8, 4'hB);
      d_c = 16'hA533; steps(2);
      d_c = 16'hB533; step();
      chk("c_stb_run", 16'(stb_c), 16'h3);
      steps(8);
      chk("c_multi_q", q_c, 16'hB533);

      // Simultaneous commits on ch0 and ch1.
      expect_commit(2, 0, cyc + 6, 4'h0);
      expect_commit(2, 1, cyc + 6, 4'hF);
      d_c = 16'hB5F0; steps(8);
      chk("c_simul_q", q_c, 16'hB5F0);
      chk("c_simul_stb", 16'(stb_c), 16'hF);

      // Boundary: FILT samples are rejected, FILT+1 samples commit.
      d_c = 16'hB5F7; steps(2); d_c = 16'hB5F0; steps(8);
      chk("c_short_q", q_c, 16'hB5F0);
      expect_commit(2, 0, cyc + 6, 4'h7);
      expect_commit(2, 0, cyc + 9, 4'h0);
      d_c = 16'hB5F7; steps(3); d_c = 16'hB5F0; steps(8);
      chk("c_exact_q", q_c, 16'hB5F0);

      chk("sb_empty", 16'(sb.size()), 16'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
